// File: rtl/sam_pkg.sv
// sam_pkg: shared SAM types and control-bus field positions for the memory responder.
package sam_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int CTRL_W = 22;
  localparam int MEM_RD_BIT = 5;
  localparam int MEM_WR_BIT = 4;
  localparam int SAM_DATA_W = 16;
  localparam int CNT_W = 4;
endpackage

// File: rtl/sam_ram.sv
// sam_ram: single-port word RAM, synchronous write, registered read; contents are never reset.
module sam_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  always_comb rdata_d = re ? mem[addr] : rdata_q;
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  always_ff @(posedge clk) rdata_q <= !rst_n ? '0 : rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/sam_mem_responder.sv
// sam_mem_responder: answers the SAM controller's memory handshake with a fixed-latency RAM access.
module sam_mem_responder
  import sam_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = SAM_DATA_W,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_en,
  output logic              wait_,
  output logic              err
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d, wait_q, wait_d, rdata_en_q, rdata_en_d, err_q, err_d;
  logic              we, re;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    we      = 1'b0;
    re      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_rd && mem_wr) err_d = 1'b1;
        else if (mem_rd || mem_wr) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          addr_d  = addr;
          wdata_d = wdata;
          wr_d    = mem_wr;
        end
      end
      BUSY: begin
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = RESP;
          we      = wr_q;
          re      = !wr_q;
        end
      end
      default: state_d = IDLE;
    endcase
    wait_d     = state_d == BUSY;
    rdata_en_d = re;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      wait_q     <= 1'b0;
      rdata_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      wait_q     <= wait_d;
      rdata_en_q <= rdata_en_d;
      err_q      <= err_d;
    end
  end
  // reset must also veto the commit edge so an aborted write never lands
  sam_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk), .rst_n(rst_n), .we(we && rst_n), .re(re && rst_n),
    .addr(addr_q), .wdata(wdata_q), .rdata(rdata)
  );
  assign wait_    = wait_q;
  assign rdata_en = rdata_en_q;
  assign err      = err_q;
endmodule

// File: doc/sam_mem_responder.md
Name: sam_mem_responder

Overview:
- Memory-side responder for the SAM microprogrammed CPU. Consumes the memory read/write strobes decoded from the controller's 22-bit control bus plus MAR address and bus write data.
- Performs the access against an internal word RAM after a fixed latency.
- Returns the wait_ status that the controller's microcode polls through its alpha/beta branch mux.
- Sits between the controller/datapath and main memory; it is the answering end of the controller's memory handshake.

Parameters:
- ADDR_W, 12, address width; RAM depth is 2**ADDR_W words.
- DATA_W, 16, word width; matches the AC/IR width (bit 15 = sign/opcode bit).
- LATENCY, 3, number of cycles wait_ stays high per access; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
- mem_rd  input  1  read strobe from the control bus; level, sampled each cycle.
- mem_wr  input  1  write strobe from the control bus; level, sampled each cycle.
- addr  input  ADDR_W  word address from MAR.
- wdata  input  DATA_W  write data from the internal bus.
- rdata  output  DATA_W  read data; registered.
- rdata_en  output  1  one-cycle pulse; enables rdata onto the internal bus (MBR load).
- wait_  output  1  1 = access in progress; controller microcode loops while 1.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, wait_=0, rdata_en=0, rdata=0, err=0, counter=0. RAM contents are not cleared. Reset overrides every other input in the same cycle.
- Reset mid-access aborts the access. A pending write is dropped because writes commit only on the BUSY->RESP edge.
- FSM states are IDLE, BUSY and RESP. All outputs are registered.
- IDLE, exactly one of mem_rd/mem_wr = 1:
  - latch addr, wdata and op;
  - load counter with LATENCY-1;
  - go to BUSY; wait_=1 from the next cycle.
  - The controller issues the strobe in one microstate and polls wait_ from the following microstate onward.
- IDLE, mem_rd=1 and mem_wr=1 together: no access, err<=1 (sticky until reset), stay IDLE, wait_ stays 0.
- BUSY:
  - Decrement counter each cycle.
  - When counter==0, go to RESP.
  - On that edge a write commits RAM[addr_q]<=wdata_q, and a read loads rdata<=RAM[addr_q].
  - wait_ is 1 for exactly LATENCY consecutive cycles.
- RESP (one cycle): wait_=0. rdata_en=1 for reads only, 0 for writes. Unconditionally return to IDLE.
- Strobes arriving in BUSY or RESP are ignored with no error. Microcode holding a strobe across several cycles is legal.
- A strobe still high on return to IDLE starts a new access. Microcode must drop strobes by the RESP cycle.
- Read-after-write to the same address returns the new data, since the write commits before any later access starts.
- rdata holds its last value until the next read completes. addr/wdata changes after the request edge have no effect.
- Address arithmetic: no wrap or offset; addr indexes RAM directly, and all ADDR_W bits are valid.
- Back-to-back throughput: one access per LATENCY+2 cycles (request edge, LATENCY busy cycles, RESP).

Decomposition:
- Shared package sam_pkg holds:
  - state enum {IDLE, BUSY, RESP};
  - bit-index constants for mem_rd/mem_wr within the 22-bit bus_controller word, so the top level slices the control bus consistently with the controller ROM;
  - the DATA_W=16 constant.
- One sub-module, sam_ram: single-port synchronous RAM with a write enable and registered read. It holds no reset on contents.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with random strobes -> wait_=0, rdata=0, err=0, rdata_en=0 throughout; RAM untouched.
- Write then read, LATENCY=3:
  - mem_wr=1, addr=0x005, wdata=0xBEEF for one cycle -> wait_=1 for exactly 3 cycles, then rdata_en=0.
  - mem_rd=1, addr=0x005 -> after 3 wait cycles, rdata=0xBEEF with rdata_en=1 for one cycle.
- Latency sweep: repeat with LATENCY=1 and LATENCY=15 -> wait_ high for exactly 1 and 15 cycles respectively.
- Held strobe: mem_rd held high for 4 cycles with LATENCY=3 -> one access only, with no err; then drop it and check that a second request is accepted normally.
- Protocol error: mem_rd=mem_wr=1 in IDLE, addr=0x010 -> err=1 sticky, wait_ stays 0, RAM[0x010] unchanged; err clears only on rst_n=0.
- Reset mid-write: mem_wr to addr=0x020, wdata=0x1234 (prior RAM value 0x0000), assert rst_n=0 in the second BUSY cycle -> state IDLE, wait_=0, and a subsequent read of 0x020 returns 0x0000.
